lvdt_thermo_tx: RTL and testbench

- Source end of the LVDT ADC interface. It generates the excitation square wave `inp` and drives the 5-bit thermometer code `adcbits` that the ADC-side logic consumes.
- The code slews one level per excitation period toward a loaded target level.
- Used as a bench/bring-up stimulus source and as an on-chip loopback for the ADC decode path.
- Only the five legal codes are ever driven: 00001, 00011, 00111, 01111, 11111.

---
 rtl/lvdt_thermo_if.sv | 13 +
 rtl/lvdt_thermo_tx.sv | 61 ++++++
 tb/tb_lvdt_thermo_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lvdt_thermo_if.sv
// lvdt_thermo_if: target/strobe inputs and thermometer/excitation outputs of the LVDT source
interface lvdt_thermo_if;
    logic [2:0] tgt;
    logic       load;
    logic [4:0] adcbits;
    logic       inp;
    logic       busy;
    logic       done;
    logic       err;
    logic       smp;
    modport master (input tgt, load, output adcbits, inp, busy, done, err, smp);
    modport slave (output tgt, load, input adcbits, inp, busy, done, err, smp);
endinterface

// File: rtl/lvdt_thermo_tx.sv
// lvdt_thermo_tx: excitation square wave plus thermometer code slewing one level per step toward a target
module lvdt_thermo_tx #(
    parameter int EXC_HALF   = 10,
    parameter int STEP_EVERY = 1
) (
    input logic           mclk,
    input logic           mrst,
    lvdt_thermo_if.master bus
);
    logic [9:0] exc_cnt;
    logic [3:0] step_cnt;
    logic [2:0] level;
    logic [2:0] target;
    logic [2:0] eff;
    logic [2:0] lvl_nx;
    logic       wrap;
    logic       rev;
    logic       fev;
    logic       legal;
    logic       ld_ok;
    logic       step;

    // excitation events, effective target (a same-cycle legal load wins) and next level
    always_comb begin
        wrap   = exc_cnt == 10'(EXC_HALF - 1);
        rev    = wrap && !bus.inp;
        fev    = wrap && bus.inp;
        legal  = bus.tgt != 3'd0 && bus.tgt <= 3'd5;
        ld_ok  = bus.load && legal;
        eff    = ld_ok ? bus.tgt : target;
        step   = rev && step_cnt == 4'(STEP_EVERY - 1);
        lvl_nx = !step ? level : (level < eff) ? level + 3'd1 : (level > eff) ? level - 3'd1 : level;
    end

    // state registers and registered outputs; code and status follow the next level
    always_ff @(posedge mclk) begin
        if (mrst) begin
            exc_cnt     <= '0;
            step_cnt    <= '0;
            level       <= 3'd1;
            target      <= 3'd1;
            bus.inp     <= 1'b0;
            bus.adcbits <= 5'b00001;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.smp     <= 1'b0;
        end else begin
            exc_cnt     <= wrap ? '0 : exc_cnt + 10'd1;
            bus.inp     <= wrap ? !bus.inp : bus.inp;
            step_cnt    <= !rev ? step_cnt : step ? '0 : step_cnt + 4'd1;
            level       <= lvl_nx;
            target      <= eff;
            bus.adcbits <= 5'((6'd1 << lvl_nx) - 6'd1);
            bus.busy    <= lvl_nx != eff;
            bus.done    <= lvl_nx == eff && (lvl_nx != level || ld_ok);
            bus.err     <= bus.load && !legal;
            bus.smp     <= fev;
        end
    end
endmodule

// File: tb/tb_lvdt_thermo_tx.sv
// tb_lvdt_thermo_tx: scoreboard bench for the LVDT thermometer source
module tb_lvdt_thermo_tx;
    typedef struct {
        int         kind;
        logic [4:0] code;
        logic       busy;
        int         at;
    } ev_t;
    typedef struct {
        logic [4:0] code;
        logic       busy;
        logic       full;
        int         at;
    } pr_t;

    logic mclk = 1'b0;
    logic mrst = 1'b1;
    lvdt_thermo_if if1();
    lvdt_thermo_if if2();

    lvdt_thermo_tx #(.EXC_HALF(10), .STEP_EVERY(1)) d1 (.mclk(mclk), .mrst(mrst), .bus(if1.master));
    lvdt_thermo_tx #(.EXC_HALF(10), .STEP_EVERY(2)) d2 (.mclk(mclk), .mrst(mrst), .bus(if2.master));

    ev_t        q1[$];
    ev_t        q2[$];
    pr_t        pq[$];
    pr_t        pcur;
    ev_t        ecur;
    int         cyc = 0;
    int         r0 = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         quiet = 1'b1;
    logic [4:0] pa1 = 5'b00001;
    logic [4:0] pa2 = 5'b00001;
    logic       pi1 = 1'b0;
    int         t;

    always #5 mclk = ~mclk;

    initial forever begin
        @(posedge mclk);
        cyc++;
    end

    // kind: 0 = code change, 1 = done, 2 = err
    task automatic sb(input int u, input int k, input logic [4:0] code, input logic b);
        n_cmp++;
        if ((u == 0 ? q1.size() : q2.size()) == 0) begin
            n_bad++;
            $display("FAIL unexpected_ev dut%0d: got kind=%0d code=%b busy=%b cyc=%0d, required no event", u + 1, k, code, b, cyc);
            return;
        end
        if (u == 0) ecur = q1.pop_front();
        else ecur = q2.pop_front();
        if (ecur.kind != k || ecur.code != code || ecur.busy != b || ecur.at != cyc) begin
            n_bad++;
            $display("FAIL ev dut%0d: got kind=%0d code=%b busy=%b cyc=%0d, required kind=%0d code=%b busy=%b cyc=%0d",
                     u + 1, k, code, b, cyc, ecur.kind, ecur.code, ecur.busy, ecur.at);
        end
    endtask

    // monitor: retires overdue expectations, matches probes and DUT events
    initial forever begin
        @(negedge mclk);
        while (q1.size() > 0 && q1[0].at < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_ev dut1: got nothing, required kind=%0d code=%b cyc=%0d", q1[0].kind, q1[0].code, q1[0].at);
            void'(q1.pop_front());
        end
        while (q2.size() > 0 && q2[0].at < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_ev dut2: got nothing, required kind=%0d code=%b cyc=%0d", q2[0].kind, q2[0].code, q2[0].at);
            void'(q2.pop_front());
        end
        while (pq.size() > 0 && pq[0].at <= cyc) begin
            pcur = pq.pop_front();
            n_cmp++;
            if (pcur.at != cyc || if1.adcbits != pcur.code || if1.busy != pcur.busy ||
                (pcur.full && {if1.inp, if1.done, if1.err, if1.smp} != 4'b0000)) begin
                n_bad++;
                $display("FAIL probe cyc=%0d: got adcbits=%b busy=%b inp/done/err/smp=%b, required adcbits=%b busy=%b zeros=%b at cyc %0d",
                         cyc, if1.adcbits, if1.busy, {if1.inp, if1.done, if1.err, if1.smp}, pcur.code, pcur.busy, pcur.full, pcur.at);
            end
        end
        if (!quiet) begin
            if (if1.adcbits != pa1) sb(0, 0, if1.adcbits, if1.busy);
            if (if1.done) sb(0, 1, if1.adcbits, if1.busy);
            if (if1.err) sb(0, 2, if1.adcbits, if1.busy);
            if (if2.adcbits != pa2) sb(1, 0, if2.adcbits, if2.busy);
            if (if2.done) sb(1, 1, if2.adcbits, if2.busy);
            if (if1.smp) begin
                n_cmp++;
                if ((cyc - r0) % 20 != 0) begin
                    n_bad++;
                    $display("FAIL smp_phase: got smp at phase %0d, required phase 0", (cyc - r0) % 20);
                end
            end
            if (if1.inp != pi1) begin
                n_cmp++;
                if (if1.inp != ((cyc - r0) % 20 >= 10)) begin
                    n_bad++;
                    $display("FAIL inp_phase: got inp=%b at phase %0d, required toggle to %b", if1.inp, (cyc - r0) % 20, !if1.inp);
                end
            end
        end
        pa1 = if1.adcbits;
        pa2 = if2.adcbits;
        pi1 = if1.inp;
    end

    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic wait_phase(input int p);
        tick();
        while ((cyc - r0) % 20 != p) tick();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && (q1.size() + q2.size() + pq.size()) > 0; i++) tick();
    endtask

    task automatic ld1(input logic [2:0] v);
        if1.tgt  = v;
        if1.load = 1'b1;
        tick();
        if1.load = 1'b0;
    endtask

    task automatic push1(input int k, input logic [4:0] c, input logic b, input int a);
        q1.push_back('{kind: k, code: c, busy: b, at: a});
    endtask

    task automatic push2(input int k, input logic [4:0] c, input logic b, input int a);
        q2.push_back('{kind: k, code: c, busy: b, at: a});
    endtask

    task automatic probe(input logic [4:0] c, input logic b, input logic f, input int a);
        pq.push_back('{code: c, busy: b, full: f, at: a});
    endtask

    initial begin
        if1.tgt = 3'd1;
        if1.load = 1'b0;
        if2.tgt = 3'd1;
        if2.load = 1'b0;
        repeat (3) tick();
        mrst = 1'b0;
        r0 = cyc;
        quiet = 1'b0;
        probe(5'b00001, 1'b0, 1'b1, cyc);
        repeat (100) tick();
        // full ascent 1 -> 5
        wait_phase(0);
        t = cyc;
        probe(5'b00001, 1'b1, 1'b1, t + 1);
        probe(5'b01111, 1'b1, 1'b1, t + 69);
        push1(0, 5'b00011, 1'b1, t + 10);
        push1(0, 5'b00111, 1'b1, t + 30);
        push1(0, 5'b01111, 1'b1, t + 50);
        push1(0, 5'b11111, 1'b0, t + 70);
        push1(1, 5'b11111, 1'b0, t + 70);
        ld1(3'd5);
        wait_empty();
        // full descent 5 -> 1
        wait_phase(0);
        t = cyc;
        push1(0, 5'b01111, 1'b1, t + 10);
        push1(0, 5'b00111, 1'b1, t + 30);
        push1(0, 5'b00011, 1'b1, t + 50);
        push1(0, 5'b00001, 1'b0, t + 70);
        push1(1, 5'b00001, 1'b0, t + 70);
        ld1(3'd1);
        wait_empty();
        // redirect to 2 while at level 3 heading for 5
        wait_phase(0);
        t = cyc;
        push1(0, 5'b00011, 1'b1, t + 10);
        push1(0, 5'b00111, 1'b1, t + 30);
        ld1(3'd5);
        wait_empty();
        wait_phase(0);
        t = cyc;
        push1(0, 5'b00011, 1'b0, t + 10);
        push1(1, 5'b00011, 1'b0, t + 10);
        ld1(3'd2);
        wait_empty();
        // illegal loads, then a load of the current level
        wait_phase(0);
        t = cyc;
        push1(2, 5'b00011, 1'b0, t + 1);
        push1(2, 5'b00011, 1'b0, t + 2);
        push1(1, 5'b00011, 1'b0, t + 3);
        probe(5'b00011, 1'b0, 1'b1, t + 4);
        ld1(3'd0);
        ld1(3'd7);
        ld1(3'd2);
        wait_empty();
        // load coinciding with the rising excitation event steps at once
        wait_phase(9);
        t = cyc;
        push1(0, 5'b00111, 1'b0, t + 1);
        push1(1, 5'b00111, 1'b0, t + 1);
        ld1(3'd3);
        wait_empty();
        // reset mid-slew at level 3, then slow-step instance run
        wait_phase(0);
        ld1(3'd5);
        repeat (4) tick();
        mrst = 1'b1;
        quiet = 1'b1;
        probe(5'b00001, 1'b0, 1'b1, cyc + 1);
        tick();
        tick();
        mrst = 1'b0;
        r0 = cyc;
        quiet = 1'b0;
        push2(0, 5'b00011, 1'b1, r0 + 30);
        push2(0, 5'b00111, 1'b0, r0 + 70);
        push2(1, 5'b00111, 1'b0, r0 + 70);
        if2.tgt = 3'd3;
        if2.load = 1'b1;
        tick();
        if2.load = 1'b0;
        wait_empty();
        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
